// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Dynamic branch predictor sitting beside fetch: direct-mapped BTB, a PHT of
//   saturating counters and (gshare only) a global history register.
//   Lookup is purely combinational from PC_F. Updates from execute land on
//   the next rising edge.
//
// Parameters
//   MODE      0 static not-taken, 1 bimodal, 2 gshare
//   ENTRIES   BTB/PHT depth (power of two, >= 4)
//   TAG_BITS  BTB tag width
//   CTR_BITS  PHT counter width (>= 1)
//   IDX       derived index width, leave at default
//   GHR_BITS  history length (<= IDX), only meaningful for MODE 2
//
// Ports
//   CLK, RST_N                     clock, async active-low reset
//   PC_F                           fetch address
//   Predict_Taken_F/Target_F       fetch prediction (target = PC_F+4 if not taken)
//   BTB_Hit_F                      BTB valid and tag match
//   Pred_Index_F                   PHT index used, travels down to execute
//   Update_En_E ... Pred_Index_E   resolved branch/jump from execute
//   Stat_Clr                       synchronous clear of the statistics
//   Resolved_Count/Mispredict_Count  saturating statistics
// ---------------------------------------------------------------------------
module branch_predictor #(
   parameter int MODE     = 1,
   parameter int ENTRIES  = 64,
   parameter int TAG_BITS = 8,
   parameter int CTR_BITS = 2,
   parameter int IDX      = $clog2(ENTRIES),
   parameter int GHR_BITS = IDX
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [31:0]     PC_F,
   output logic            Predict_Taken_F,
   output logic [31:0]     Predict_Target_F,
   output logic            BTB_Hit_F,
   output logic [IDX-1:0]  Pred_Index_F,
   input  logic            Update_En_E,
   input  logic            Is_Jump_E,
   input  logic [31:0]     PC_E,
   input  logic [31:0]     PC_Target_E,
   input  logic            Branch_Taken_E,
   input  logic            Predict_Taken_E,
   input  logic [IDX-1:0]  Pred_Index_E,
   input  logic            Stat_Clr,
   output logic [31:0]     Resolved_Count,
   output logic [31:0]     Mispredict_Count
);

   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   // Weakly not-taken: 01 for 2-bit counters, 0 for 1-bit.
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

   // Valid bits and counters are reset; tags and targets are plain storage.
   logic [ENTRIES-1:0]               valid_q, valid_d;
   logic [TAG_BITS-1:0]              tag_q [ENTRIES];
   logic [31:0]                      tgt_q [ENTRIES];
   logic [ENTRIES-1:0][CTR_BITS-1:0] pht_q, pht_d;
   logic [GHR_BITS-1:0]              ghr_q, ghr_d;
   logic [31:0]                      res_q, res_d;
   logic [31:0]                      mis_q, mis_d;

   // ---------------- fetch-side lookup ----------------
   logic [IDX-1:0]      f_idx;
   logic [TAG_BITS-1:0] f_tag;
   logic [IDX-1:0]      pred_idx;

   assign f_idx = PC_F[IDX+1:2];
   assign f_tag = PC_F[IDX+TAG_BITS+1:IDX+2];

   always_comb begin
      pred_idx = '0;
      if (MODE == 1)      pred_idx = f_idx;
      else if (MODE == 2) pred_idx = f_idx ^ IDX'(ghr_q);
   end

   assign BTB_Hit_F        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign Pred_Index_F     = pred_idx;
   assign Predict_Taken_F  = (MODE != 0) && BTB_Hit_F && pht_q[pred_idx][CTR_BITS-1];
   assign Predict_Target_F = Predict_Taken_F ? tgt_q[f_idx] : PC_F + 32'd4;

   // ---------------- execute-side update ----------------
   logic [IDX-1:0]      e_idx;
   logic [TAG_BITS-1:0] e_tag;
   logic                btb_we;
   logic [CTR_BITS-1:0] ctr_cur;

   assign e_idx   = PC_E[IDX+1:2];
   assign e_tag   = PC_E[IDX+TAG_BITS+1:IDX+2];
   // Only taken outcomes allocate; not-taken never touches the BTB.
   assign btb_we  = Update_En_E && Branch_Taken_E;
   assign ctr_cur = pht_q[Pred_Index_E];

   always_comb begin
      pht_d = pht_q;
      if (Update_En_E) begin
         if (Is_Jump_E)                              pht_d[Pred_Index_E] = CTR_MAX;
         else if (Branch_Taken_E && ctr_cur != CTR_MAX) pht_d[Pred_Index_E] = ctr_cur + 1'b1;
         else if (!Branch_Taken_E && ctr_cur != '0)     pht_d[Pred_Index_E] = ctr_cur - 1'b1;
      end
   end

   always_comb begin
      valid_d = valid_q;
      if (btb_we) valid_d[e_idx] = 1'b1;
   end

   // History shifts on conditional branches only; the cast drops the oldest bit.
   always_comb begin
      ghr_d = ghr_q;
      if (MODE == 2 && Update_En_E && !Is_Jump_E)
         ghr_d = GHR_BITS'({ghr_q, Branch_Taken_E});
   end

   // Clear wins over a same-edge increment; both counters stick at all-ones.
   always_comb begin
      res_d = res_q;
      mis_d = mis_q;
      if (Stat_Clr) begin
         res_d = '0;
         mis_d = '0;
      end else if (Update_En_E) begin
         if (res_q != '1) res_d = res_q + 32'd1;
         if (Predict_Taken_E != Branch_Taken_E && mis_q != '1) mis_d = mis_q + 32'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         valid_q <= '0;
         pht_q   <= {ENTRIES{CTR_INIT}};
         ghr_q   <= '0;
         res_q   <= '0;
         mis_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pht_q   <= pht_d;
         ghr_q   <= ghr_d;
         res_q   <= res_d;
         mis_q   <= mis_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (btb_we) begin
         tag_q[e_idx] <= e_tag;
         tgt_q[e_idx] <= PC_Target_E;
      end
   end

   assign Resolved_Count   = res_q;
   assign Mispredict_Count = mis_q;

   // Low offset bits and high PC bits beyond the tag are deliberately ignored.
   logic unused_pc;
   assign unused_pc = ^{PC_F, PC_E};

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
   localparam int ENTRIES = 64, IDX = 6, TAG_BITS = 8, GB = 2;
   localparam int CMAX = 3, HALF = 2, CINIT = 1;

   logic        CLK, RST_N;
   logic [31:0] PC_F, PC_E, PC_Target_E;
   logic        Update_En_E, Is_Jump_E, Branch_Taken_E, Predict_Taken_E, Stat_Clr;
   logic [IDX-1:0] pie [3];
   logic        pt [3];
   logic [31:0] ptgt [3];
   logic        hit [3];
   logic [IDX-1:0] pif [3];
   logic [31:0] rc [3], mc [3];

   int n_cmp = 0, n_bad = 0;

   // Three instances sharing stimulus: MODE 0, MODE 1, MODE 2 (2-bit history).
   for (genvar g = 0; g < 3; g++) begin : g_dut
      branch_predictor #(.MODE(g), .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CTR_BITS(2),
                         .GHR_BITS(g == 2 ? GB : IDX)) u_dut (
         .CLK(CLK), .RST_N(RST_N), .PC_F(PC_F),
         .Predict_Taken_F(pt[g]), .Predict_Target_F(ptgt[g]), .BTB_Hit_F(hit[g]),
         .Pred_Index_F(pif[g]), .Update_En_E(Update_En_E), .Is_Jump_E(Is_Jump_E),
         .PC_E(PC_E), .PC_Target_E(PC_Target_E), .Branch_Taken_E(Branch_Taken_E),
         .Predict_Taken_E(Predict_Taken_E), .Pred_Index_E(pie[g]), .Stat_Clr(Stat_Clr),
         .Resolved_Count(rc[g]), .Mispredict_Count(mc[g]));
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- behavioural model ----------------
   bit          m_valid [ENTRIES];
   int          m_tag   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_pht   [3][ENTRIES];
   int          m_ghr;
   logic [31:0] m_res, m_mis;

   function automatic int bidx(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction
   function automatic int ptag(input logic [31:0] pc);
      return int'((pc >> (IDX + 2)) % (1 << TAG_BITS));
   endfunction
   function automatic int fidx(input int mode, input logic [31:0] pc);
      if (mode == 0) return 0;
      if (mode == 1) return bidx(pc);
      return bidx(pc) ^ m_ghr;
   endfunction
   function automatic bit mhit(input logic [31:0] pc);
      return m_valid[bidx(pc)] && m_tag[bidx(pc)] == ptag(pc);
   endfunction
   function automatic bit mtaken(input int mode, input logic [31:0] pc);
      return mode != 0 && mhit(pc) && m_pht[mode][fidx(mode, pc)] >= HALF;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 0;
         for (int m = 0; m < 3; m++) m_pht[m][i] = CINIT;
      end
      m_ghr = 0; m_res = 0; m_mis = 0;
   endtask

   task automatic model_update();
      bit tk;
      int b, i;
      tk = Branch_Taken_E;
      b  = bidx(PC_E);
      if (Update_En_E) begin
         for (int m = 0; m < 3; m++) begin
            i = int'(pie[m]);
            if (Is_Jump_E)  m_pht[m][i] = CMAX;
            else if (tk)    m_pht[m][i] = (m_pht[m][i] >= CMAX) ? CMAX : m_pht[m][i] + 1;
            else            m_pht[m][i] = (m_pht[m][i] == 0) ? 0 : m_pht[m][i] - 1;
         end
         if (tk) begin
            m_valid[b] = 1; m_tag[b] = ptag(PC_E); m_tgt[b] = PC_Target_E;
         end
         if (!Is_Jump_E) m_ghr = (m_ghr * 2 + int'(tk)) % (1 << GB);
         if (m_res != 32'hFFFF_FFFF) m_res = m_res + 1;
         if (Predict_Taken_E != tk && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
      end
      if (Stat_Clr) begin m_res = 0; m_mis = 0; end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Every cycle, away from the active edge, all instances against the model.
   always @(negedge CLK) begin
      for (int g = 0; g < 3; g++) begin
         bit tk;
         tk = mtaken(g, PC_F);
         chk($sformatf("m%0d taken", g), 32'(pt[g]), 32'(tk));
         chk($sformatf("m%0d target", g), ptgt[g], tk ? m_tgt[bidx(PC_F)] : PC_F + 32'd4);
         chk($sformatf("m%0d hit", g), 32'(hit[g]), 32'(mhit(PC_F)));
         chk($sformatf("m%0d index", g), 32'(pif[g]), 32'(fidx(g, PC_F)));
         chk($sformatf("m%0d resolved", g), rc[g], m_res);
         chk($sformatf("m%0d mispred", g), mc[g], m_mis);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge CLK);
      if (RST_N) model_update();
      #1;
   endtask

   task automatic set_upd(input logic [31:0] pc, tgt, input logic tk, jp, clr);
      PC_E = pc; PC_Target_E = tgt; Is_Jump_E = jp; Branch_Taken_E = tk | jp;
      Predict_Taken_E = mtaken(1, pc);
      for (int g = 0; g < 3; g++) pie[g] = IDX'(fidx(g, pc));
      Update_En_E = 1'b1; Stat_Clr = clr;
   endtask

   task automatic resolve(input logic [31:0] pc, tgt, input logic tk, jp, clr);
      set_upd(pc, tgt, tk, jp, clr);
      tick();
      Update_En_E = 1'b0; Stat_Clr = 1'b0;
   endtask

   function automatic logic [31:0] pool();
      return (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
   endfunction

   initial begin
      RST_N = 1'b0; PC_F = 32'h100; PC_E = '0; PC_Target_E = '0;
      Update_En_E = 0; Is_Jump_E = 0; Branch_Taken_E = 0; Predict_Taken_E = 0; Stat_Clr = 0;
      for (int g = 0; g < 3; g++) pie[g] = '0;
      model_reset();
      #2;
      chk("reset taken", 32'(pt[1]), 32'd0);
      chk("reset hit", 32'(hit[1]), 32'd0);
      chk("reset target", ptgt[1], 32'h104);
      chk("reset resolved", rc[1], 32'd0);
      chk("reset mispred", mc[1], 32'd0);
      tick(); tick();
      RST_N = 1'b1;
      tick();

      // Training: first taken resolve at 0x100 -> counter 2, BTB allocated.
      resolve(32'h100, 32'h40, 1, 0, 0);
      chk("train hit", 32'(hit[1]), 32'd1);
      chk("train taken", 32'(pt[1]), 32'd1);
      chk("train target", ptgt[1], 32'h40);
      chk("train mispred", mc[1], 32'd1);
      chk("mode0 taken", 32'(pt[0]), 32'd0);
      chk("mode0 target", ptgt[0], 32'h104);

      // Saturation: 4 more taken (5 total), then not-taken twice.
      repeat (4) resolve(32'h100, 32'h40, 1, 0, 0);
      resolve(32'h100, 32'h40, 0, 0, 0);
      chk("sat nt1 taken", 32'(pt[1]), 32'd1);
      resolve(32'h100, 32'h40, 0, 0, 0);
      chk("sat nt2 taken", 32'(pt[1]), 32'd0);
      chk("sat nt2 hit", 32'(hit[1]), 32'd1);

      // Aliasing: 0x200 shares index 0 with 0x100 but has a different tag.
      resolve(32'h200, 32'h80, 1, 0, 0);
      PC_F = 32'h100; #1;
      chk("alias old hit", 32'(hit[1]), 32'd0);
      PC_F = 32'h200; #1;
      chk("alias new taken", 32'(pt[1]), 32'd1);
      chk("alias new target", ptgt[1], 32'h80);

      // Same-edge lookup/update: old contents before the edge, new after.
      PC_F = 32'h104;
      set_upd(32'h104, 32'h10, 1, 0, 0); #1;
      chk("same-edge old hit", 32'(hit[1]), 32'd0);
      tick();
      Update_En_E = 1'b0;
      chk("same-edge new hit", 32'(hit[1]), 32'd1);
      chk("same-edge new target", ptgt[1], 32'h10);

      // Asynchronous reset in the middle of an update cycle.
      set_upd(32'h108, 32'h20, 1, 0, 0);
      #2; RST_N = 1'b0; model_reset(); #1;
      chk("async rst hit", 32'(hit[1]), 32'd0);
      chk("async rst taken", 32'(pt[1]), 32'd0);
      chk("async rst resolved", rc[1], 32'd0);
      @(posedge CLK); #2;
      RST_N = 1'b1;
      set_upd(32'h108, 32'h20, 1, 0, 0);
      tick();
      Update_En_E = 1'b0;
      PC_F = 32'h108; #1;
      chk("post-rst update hit", 32'(hit[1]), 32'd1);
      chk("post-rst resolved", rc[1], 32'd1);

      // Stat_Clr coinciding with an update.
      resolve(32'h10C, 32'h30, 1, 0, 1);
      chk("clr resolved", rc[1], 32'd0);
      chk("clr mispred", mc[1], 32'd0);

      // Gshare: fresh state, alternating T/N at 0x100, 2-bit history.
      RST_N = 1'b0; model_reset();
      tick();
      RST_N = 1'b1;
      PC_F = 32'h100;
      for (int k = 0; k < 8; k++) begin
         logic tk;
         tk = (k % 2 == 0);
         #1;
         if (k >= 4) begin
            chk($sformatf("gshare idx k%0d", k), 32'(pif[2]), (k % 2 == 0) ? 32'd2 : 32'd1);
            chk($sformatf("gshare pred k%0d", k), 32'(pt[2]), 32'(tk));
         end
         resolve(32'h100, 32'h40, tk, 0, 0);
      end

      // Randomised traffic over a small aliasing PC pool.
      for (int n = 0; n < 500; n++) begin
         PC_F = pool();
         if ($urandom_range(0, 1) == 1)
            resolve(pool(), pool(), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 31) == 0);
         else
            tick();
      end

      @(negedge CLK); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the RV32i pipeline. It replaces the fixed prediction path in fetch with three pieces: a direct-mapped branch target buffer (BTB), a pattern history table (PHT) of saturating counters, and an optional global history register (GHR). Fetch reads a same-cycle prediction for PC_F. Execute writes back each resolved branch or jump one edge later. It sits beside fetch, and its prediction index travels down the IF/ID and ID/EX registers with Predict_Taken.

## Interface
- MODE, default 1: prediction mode.
  - 0: static not-taken.
  - 1: bimodal, PHT indexed by PC.
  - 2: gshare, PHT indexed by PC XOR GHR.
- ENTRIES, default 64: BTB and PHT depth. Power of 2, minimum 4. IDX = log2(ENTRIES).
- TAG_BITS, default 8: BTB tag width.
- CTR_BITS, default 2: PHT counter width, minimum 1.
- GHR_BITS, default IDX: history length, at most IDX. Used only in MODE 2.

Ports:
- CLK  in  1  system clock. Everything is rising-edge.
- RST_N  in  1  asynchronous, active-low reset.
- PC_F  in  32  fetch address.
- Predict_Taken_F  out  1  predict taken, used to redirect fetch.
- Predict_Target_F  out  32  predicted target; valid only when Predict_Taken_F=1.
- BTB_Hit_F  out  1  BTB entry valid and tag matches.
- Pred_Index_F  out  IDX  PHT index used for this lookup; pipelined to execute.
- Update_En_E  in  1  a valid branch or jump resolved this cycle.
- Is_Jump_E  in  1  the resolved instruction is JAL/JALR.
- PC_E  in  32  PC of the resolved instruction.
- PC_Target_E  in  32  resolved target.
- Branch_Taken_E  in  1  actual outcome; must be 1 for jumps.
- Predict_Taken_E  in  1  prediction made at fetch for this instruction.
- Pred_Index_E  in  IDX  Pred_Index_F, pipelined.
- Stat_Clr  in  1  synchronous clear of the statistics counters.
- Resolved_Count  out  32  number of updates.
- Mispredict_Count  out  32  number of direction mispredictions.

## Operation
- Field split:
  - BTB index = PC[IDX+1:2].
  - Tag = PC[IDX+TAG_BITS+1:IDX+2].
  - BTB entry = {valid, tag, target[31:0]}.
- PHT index, fetch side:
  - MODE 1: PC_F[IDX+1:2].
  - MODE 2: PC_F[IDX+1:2] XOR zero-extended GHR.
  - MODE 0: 0.
- Predict_Taken_F = (MODE≠0) & BTB_Hit_F & PHT[Pred_Index_F][CTR_BITS-1].
  - Predict_Target_F = BTB target when Predict_Taken_F=1, otherwise PC_F+4.
- On an edge with Update_En_E=1, all of the following happen together:
  - PHT[Pred_Index_E], branches: +1 if Branch_Taken_E, −1 if not, saturating at 0 and 2^CTR_BITS−1.
  - PHT[Pred_Index_E], jumps: set to 2^CTR_BITS−1.
  - BTB: if Branch_Taken_E=1, write {1, tag(PC_E), PC_Target_E} at index(PC_E). The entry is overwritten even if a different tag was there.
  - BTB: a not-taken update leaves the BTB unchanged. A not-taken result never allocates and never invalidates.
  - GHR (MODE 2, branches only): GHR <= {GHR[GHR_BITS-2:0], Branch_Taken_E}. Jumps do not shift the GHR.
  - Statistics: Resolved_Count +1. Mispredict_Count +1 when Predict_Taken_E≠Branch_Taken_E.
- Statistics counters saturate at 0xFFFFFFFF and never wrap.
- Stat_Clr=1 zeroes both statistics counters. It has priority over a same-edge increment.
- In MODE 0 the tables still update and the statistics still count; only the prediction outputs are forced (not taken, target PC_F+4).

## Timing
- Lookup is combinational from PC_F and registered table state: zero-cycle latency, valid in the same cycle PC_F is presented.
- Update latency is one edge. A lookup in the same cycle as an update to the same entry returns the old contents. The new contents are visible from the next cycle.
- The block has no stall input. Fetch holds PC_F during a stall, so the outputs hold. An update during a stall is still applied.
- Reset (RST_N low, any time, including mid-update):
  - All BTB valid bits = 0.
  - All PHT counters = 2^(CTR_BITS−1)−1 (weakly not-taken; 01 for 2-bit counters, 0 for 1-bit).
  - GHR = 0. Both statistics counters = 0.
  - Predict_Taken_F = 0, BTB_Hit_F = 0 immediately.
  - BTB tags and targets are not reset.
  - The first edge after RST_N rises may apply an update.
- A 1-bit PHT (CTR_BITS=1) behaves as last-outcome: predict taken iff the last resolved outcome at that index was taken.

## Test plan
- Reset, MODE 1, defaults: hold RST_N=0 and drive PC_F=0x100 -> Predict_Taken_F=0, BTB_Hit_F=0, Predict_Target_F=0x104, both statistics counters 0.
- Training: taken branch at PC_E=0x100 with target 0x40 and Predict_Taken_E=0 -> next cycle PC_F=0x100 gives BTB_Hit_F=1, counter 2, Predict_Taken_F=1, Predict_Target_F=0x40, Mispredict_Count=1.
- Saturation: resolve PC 0x100 taken 5 times, then not-taken once -> counter sticks at 3 then drops to 2, prediction stays taken. A second not-taken -> counter 1, Predict_Taken_F=0, BTB_Hit_F stays 1.
- Aliasing: train taken at 0x100, then taken at 0x100+4·ENTRIES (0x200) with target 0x80 -> lookup of 0x100 gives BTB_Hit_F=0 and lookup of 0x200 gives target 0x80.
- Gshare, MODE 2: train taken/not-taken alternating at PC 0x100 for 8 updates -> GHR shifts each update, Pred_Index_F differs by history, and the last 4 predictions are correct.
- Same-edge update and lookup on the same entry -> old value in that cycle, new value the next cycle.
- Asynchronous reset mid-update -> tables reinitialise immediately.
- Statistics saturation: preload Resolved_Count=0xFFFFFFFE via 2 updates -> 0xFFFFFFFF holds.
- Stat_Clr on the same edge as an update -> both counters 0.
